ram_param: RTL and testbench
============================

RAM_PARAM -- requirements
Module: ram_param

Interface
REQ-001 Parameter DATA_W, default 16: word width in bits; SHALL be a multiple of 8, otherwise elaboration fails.
REQ-002 Parameter DEPTH, default 10: number of words.
REQ-003 Parameter ADDR_W, default 6: address width; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-006 clr_req  in  1  request a hardware clear of the whole array.
REQ-007 busy  out  1  high while the clear sequence runs.
REQ-008 we  in  1  write strobe.
REQ-009 be  in  DATA_W/8  byte enables for the write; bit i covers wd[8i+7:8i].
REQ-010 wa  in  ADDR_W  write address.
REQ-011 wd  in  DATA_W  write data.
REQ-012 re  in  1  read strobe.
REQ-013 ra  in  ADDR_W  read address.
REQ-014 rd  out  DATA_W  registered read data.
REQ-015 rvalid  out  1  rd holds the result of the read issued in the previous cycle.
REQ-016 err  out  1  one-cycle pulse for an out-of-range access.

Function
REQ-017 Write: we=1, busy=0 and wa<DEPTH SHALL update only the enabled bytes of mem[wa] at the clock edge.
REQ-018 Read latency SHALL be 1 cycle: re=1 in cycle N SHALL produce rd and rvalid=1 in cycle N+1.
REQ-019 rvalid SHALL be 0 in any cycle not preceded by an accepted read; rd SHALL hold its last value when rvalid=0.
REQ-020 Same-address read and write in one cycle SHALL be write-first: rd returns the old word merged with the enabled new bytes.
REQ-021 Address >= DEPTH on an active strobe: write discarded, read returns rd=0 with rvalid=1, and err pulses in the next cycle; simultaneous bad read and bad write produce a single err pulse.
REQ-022 The clear FSM SHALL have two states, IDLE and CLEAR; CLEAR writes 0 to one word per cycle, with a counter running 0..DEPTH-1, then returns to IDLE.
REQ-023 A CLEAR sequence SHALL take exactly DEPTH cycles, and busy SHALL be 1 for exactly those cycles.
REQ-024 clr_req=1 in IDLE SHALL enter CLEAR at the next edge; clr_req during CLEAR SHALL be ignored, with no restart and no extension.
REQ-025 While busy=1, we and re SHALL be ignored: no memory update, rvalid=0, err=0.
REQ-026 clr_req, we and re in the same IDLE cycle: the write and read complete normally, then CLEAR starts.

Reset
REQ-027 While rst_n=0: FSM=CLEAR, counter=0, busy=1, rd=0, rvalid=0, err=0.
REQ-028 After rst_n deasserts, a full DEPTH-cycle clear SHALL run before busy drops; no memory initialisation other than this sequence exists.
REQ-029 Reset asserted mid-clear SHALL restart the sequence from word 0 after release.

Structure
REQ-030 Shared package ram_pkg SHALL hold the parameter defaults and the clear-FSM state type (IDLE, CLEAR).
REQ-031 The FSM and counter SHALL live in the sub-module ram_clr_fsm (outputs busy, clear address, clear write enable); the array, byte merge, read register and error logic stay in ram_param.

Verification (DATA_W=16, DEPTH=10, ADDR_W=6)
REQ-032 Release rst_n -> busy=1 for exactly 10 cycles; then reads of addresses 0..9 -> rd=0x0000, rvalid=1 one cycle after each re.
REQ-033 Write 0xBEEF to address 3 with be=11, then re at address 3 -> rd=0xBEEF one cycle later; next write 0x1234 with be=01 -> read returns 0xBE34.
REQ-034 Write 0xA5A5 to address 5 and read address 5 in the same cycle -> rd=0xA5A5 next cycle.
REQ-035 Write to address 12, then read address 12 -> err pulses once per access, rd=0x0000, and addresses 0..9 are unchanged.
REQ-036 Fill all words, clr_req=1, assert rst_n at counter=4 then release -> busy high for 10 more cycles; we/re during busy are ignored; every word reads 0x0000 afterwards.

Source files
------------

// File: rtl/ram_pkg.sv
// ---------------------------------------------------------------------------
// ram_pkg : shared defaults and clear-FSM state type for ram_param
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram_pkg;

  localparam int c_data_w_def = 16;
  localparam int c_depth_def  = 10;
  localparam int c_addr_w_def = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/ram_clr_fsm.sv
// ---------------------------------------------------------------------------
// ram_clr_fsm : walks a zero-write over every word after reset or on request
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int DEPTH  = c_depth_def,
  parameter int ADDR_W = c_addr_w_def
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_req,
  output logic              busy,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_we
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  clr_state_t        r_state;
  clr_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_cnt_nxt;

  // Reset parks the FSM in CLEAR so the array is always initialised on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    clr_we      = 1'b0;
    clr_addr    = r_cnt;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (r_cnt == c_last) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/ram_param.sv
// ---------------------------------------------------------------------------
// ram_param : byte-enabled 1R1W RAM with write-first read, range error pulse
//             and a hardware clear sequence
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram_param
  import ram_pkg::*;
#(
  parameter int DATA_W = c_data_w_def,
  parameter int DEPTH  = c_depth_def,
  parameter int ADDR_W = c_addr_w_def
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  output logic                busy,
  input  logic                we,
  input  logic [DATA_W/8-1:0] be,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic                re,
  input  logic [ADDR_W-1:0]   ra,
  output logic [DATA_W-1:0]   rd,
  output logic                rvalid,
  output logic                err
);

  localparam int              c_nbytes = DATA_W / 8;
  localparam int              c_idx_w  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] c_depth  = (ADDR_W + 1)'(DEPTH);

  generate
    if (DATA_W % 8 != 0) begin : g_bad_data_w
      $error("ram_param: DATA_W must be a multiple of 8");
    end
    if (DEPTH > 2 ** ADDR_W) begin : g_bad_depth
      $error("ram_param: DEPTH exceeds 2**ADDR_W");
    end
  endgenerate

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic               w_clr_we;
  logic [ADDR_W-1:0]  w_clr_addr;
  logic               w_wr_req;
  logic               w_rd_req;
  logic               w_wa_ok;
  logic               w_ra_ok;
  logic               w_wr_ok;
  logic [c_idx_w-1:0] w_wa_idx;
  logic [c_idx_w-1:0] w_ra_idx;
  logic [c_idx_w-1:0] w_clr_idx;
  logic [DATA_W-1:0]  w_old;
  logic [DATA_W-1:0]  w_merged;
  logic [DATA_W-1:0]  w_rd_nxt;

  ram_clr_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .busy     (busy),
    .clr_addr (w_clr_addr),
    .clr_we   (w_clr_we)
  );

  // User strobes are dead while the clear sequence owns the array
  assign w_wr_req  = we & ~busy;
  assign w_rd_req  = re & ~busy;
  assign w_wa_ok   = {1'b0, wa} < c_depth;
  assign w_ra_ok   = {1'b0, ra} < c_depth;
  assign w_wr_ok   = w_wr_req & w_wa_ok;
  assign w_wa_idx  = wa[c_idx_w-1:0];
  assign w_ra_idx  = ra[c_idx_w-1:0];
  assign w_clr_idx = w_clr_addr[c_idx_w-1:0];
  assign w_old     = w_wa_ok ? r_mem[w_wa_idx] : '0;

  generate
    for (genvar gi = 0; gi < c_nbytes; gi++) begin : g_byte
      assign w_merged[8*gi +: 8] = be[gi] ? wd[8*gi +: 8] : w_old[8*gi +: 8];
    end
  endgenerate

  // Write-first: a same-address read sees the merged word being written
  always_comb begin
    w_rd_nxt = '0;
    if (w_ra_ok) begin
      if (w_wr_ok && (wa == ra)) begin
        w_rd_nxt = w_merged;
      end else begin
        w_rd_nxt = r_mem[w_ra_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_wr_ok) begin
      r_mem[w_wa_idx] <= w_merged;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd     <= '0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= w_rd_req;
      err    <= (w_wr_req & ~w_wa_ok) | (w_rd_req & ~w_ra_ok);
      if (w_rd_req) begin
        rd <= w_rd_nxt;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_param.sv
// ---------------------------------------------------------------------------
// tb_ram_param : randomized and directed checks of ram_param against a model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram_param;

  localparam int c_dw    = 16;
  localparam int c_depth = 10;
  localparam int c_aw    = 6;

  logic              clk;
  logic              rst_n;
  logic              clr_req;
  logic              busy;
  logic              we;
  logic [1:0]        be;
  logic [c_aw-1:0]   wa;
  logic [c_dw-1:0]   wd;
  logic              re;
  logic [c_aw-1:0]   ra;
  logic [c_dw-1:0]   rd;
  logic              rvalid;
  logic              err;

  ram_param #(
    .DATA_W (c_dw),
    .DEPTH  (c_depth),
    .ADDR_W (c_aw)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_req (clr_req),
    .busy    (busy),
    .we      (we),
    .be      (be),
    .wa      (wa),
    .wd      (wd),
    .re      (re),
    .ra      (ra),
    .rd      (rd),
    .rvalid  (rvalid),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_pass;
  int          n_total;
  logic [15:0] m_mem [c_depth];
  int          m_left;
  logic [15:0] m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle of stimulus, called at posedge+1; checks outputs after the edge
  task automatic cycle(input logic i_we, input logic [1:0] i_be, input int i_wa,
                       input logic [15:0] i_wd, input logic i_re, input int i_ra,
                       input logic i_clr);
    logic [15:0] old;
    logic [15:0] merged;
    logic        exp_rv;
    logic        exp_err;
    logic [5:0]  a6;
    a6 = 6'(i_wa); wa = a6;
    a6 = 6'(i_ra); ra = a6;
    we = i_we; be = i_be; wd = i_wd; re = i_re; clr_req = i_clr;
    #1;
    check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    exp_rv  = 1'b0;
    exp_err = 1'b0;
    if (m_left > 0) begin
      m_left--;
    end else begin
      old = (i_wa < c_depth) ? m_mem[i_wa] : 16'h0000;
      merged = old;
      if (i_be[0]) merged[7:0]  = i_wd[7:0];
      if (i_be[1]) merged[15:8] = i_wd[15:8];
      if (i_re) begin
        exp_rv = 1'b1;
        if (i_ra >= c_depth)                m_rd = 16'h0000;
        else if (i_we && (i_wa == i_ra) && (i_wa < c_depth)) m_rd = merged;
        else                                m_rd = m_mem[i_ra];
      end
      exp_err = (i_we && (i_wa >= c_depth)) || (i_re && (i_ra >= c_depth));
      if (i_we && (i_wa < c_depth)) m_mem[i_wa] = merged;
      if (i_clr) begin
        m_left = c_depth;
        for (int k = 0; k < c_depth; k++) m_mem[k] = 16'h0000;
      end
    end
    @(posedge clk);
    #1;
    check("rvalid", {31'd0, rvalid}, {31'd0, exp_rv});
    check("rd", {16'd0, rd}, {16'd0, m_rd});
    check("err", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 2'b00, 0, 16'h0000, 1'b0, 0, 1'b0);
  endtask

  task automatic junk_cycle();
    cycle(1'($urandom), 2'($urandom), int'($urandom_range(0, 12)), 16'($urandom),
          1'($urandom), int'($urandom_range(0, 12)), 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0; n_total = 0;
    m_left = 0; m_rd = 16'h0000;
    for (int k = 0; k < c_depth; k++) m_mem[k] = 16'h0000;
    rst_n = 1'b0; clr_req = 1'b0; we = 1'b0; be = 2'b00;
    wa = '0; wd = '0; re = 1'b0; ra = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_rd", {16'd0, rd}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);

    // Release: full clear with junk strobes ignored, then every word reads zero
    rst_n = 1'b1;
    m_left = c_depth;
    repeat (c_depth) junk_cycle();
    for (int a = 0; a < c_depth; a++) cycle(1'b0, 2'b00, 0, 16'h0, 1'b1, a, 1'b0);
    idle_cycle();

    // Byte enables
    cycle(1'b1, 2'b11, 3, 16'hBEEF, 1'b0, 0, 1'b0);
    cycle(1'b0, 2'b00, 0, 16'h0000, 1'b1, 3, 1'b0);
    cycle(1'b1, 2'b01, 3, 16'h1234, 1'b0, 0, 1'b0);
    cycle(1'b0, 2'b00, 0, 16'h0000, 1'b1, 3, 1'b0);
    check("be_merge", {16'd0, rd}, 32'h0000BE34);
    idle_cycle();

    // Write-first same-address access
    cycle(1'b1, 2'b11, 5, 16'hA5A5, 1'b1, 5, 1'b0);
    check("write_first", {16'd0, rd}, 32'h0000A5A5);

    // Out-of-range write, read, and both together
    cycle(1'b1, 2'b11, 12, 16'hFFFF, 1'b0, 0, 1'b0);
    idle_cycle();
    cycle(1'b0, 2'b00, 0, 16'h0000, 1'b1, 12, 1'b0);
    idle_cycle();
    cycle(1'b1, 2'b11, 63, 16'hFFFF, 1'b1, 10, 1'b0);
    idle_cycle();
    for (int a = 0; a < c_depth; a++) cycle(1'b0, 2'b00, 0, 16'h0, 1'b1, a, 1'b0);

    // Clear request together with write and read in the same idle cycle
    cycle(1'b1, 2'b11, 7, 16'h7777, 1'b1, 7, 1'b1);
    check("clr_same_cycle_rd", {16'd0, rd}, 32'h00007777);
    for (int i = 0; i < c_depth; i++)
      cycle(1'($urandom), 2'($urandom), int'($urandom_range(0, 9)), 16'($urandom),
            1'($urandom), int'($urandom_range(0, 9)), 1'b1);
    for (int a = 0; a < c_depth; a++) cycle(1'b0, 2'b00, 0, 16'h0, 1'b1, a, 1'b0);

    // Randomized traffic with occasional clear requests
    for (int i = 0; i < 250; i++)
      cycle(1'($urandom), 2'($urandom), int'($urandom_range(0, 12)), 16'($urandom),
            1'($urandom), int'($urandom_range(0, 12)), 1'($urandom_range(0, 29) == 0));
    while (m_left > 0) idle_cycle();

    // Fill, request clear, reset at counter=4, verify full restart
    for (int a = 0; a < c_depth; a++)
      cycle(1'b1, 2'b11, a, 16'hC000 + 16'(a), 1'b0, 0, 1'b0);
    cycle(1'b0, 2'b00, 0, 16'h0000, 1'b0, 0, 1'b1);
    repeat (4) junk_cycle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd1);
    check("mid_rst_rd", {16'd0, rd}, 32'd0);
    check("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_rst_err", {31'd0, err}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_left = c_depth;
    m_rd = 16'h0000;
    for (int k = 0; k < c_depth; k++) m_mem[k] = 16'h0000;
    repeat (c_depth) junk_cycle();
    for (int a = 0; a < c_depth; a++) begin
      cycle(1'b0, 2'b00, 0, 16'h0, 1'b1, a, 1'b0);
      check("post_clear_zero", {16'd0, rd}, 32'd0);
    end
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
